// File: rtl/bsg_iic_cmd_to_link_if.sv
// Host-facing command/data channels and the ready-and link pair of the IIC link client.
// Link vectors are packed as {v, data, ready_and_rev}.
interface bsg_iic_cmd_to_link_if #(
    parameter int unsigned iic_data_bits_p = 8,
    parameter int unsigned cord_width_p    = 4,
    parameter int unsigned len_width_p     = 4
);
    localparam int unsigned link_width_lp = iic_data_bits_p + 2;

    logic                     cmd_v_i;
    logic                     cmd_ready_o;
    logic [6:0]               cmd_addr_i;
    logic                     cmd_read_i;
    logic [len_width_p-1:0]   cmd_len_i;
    logic                     cmd_rs_i;

    logic                     wdata_v_i;
    logic [7:0]               wdata_i;
    logic                     wdata_ready_o;

    logic                     rdata_v_o;
    logic [7:0]               rdata_o;
    logic                     rdata_ready_i;

    logic                     done_v_o;
    logic                     done_err_o;

    logic [link_width_lp-1:0] link_i;
    logic [link_width_lp-1:0] link_o;

    // Host / bridge side
    modport master (
        output cmd_v_i, cmd_addr_i, cmd_read_i, cmd_len_i, cmd_rs_i,
        output wdata_v_i, wdata_i, rdata_ready_i, link_i,
        input  cmd_ready_o, wdata_ready_o, rdata_v_o, rdata_o,
        input  done_v_o, done_err_o, link_o
    );

    // Client block side
    modport slave (
        input  cmd_v_i, cmd_addr_i, cmd_read_i, cmd_len_i, cmd_rs_i,
        input  wdata_v_i, wdata_i, rdata_ready_i, link_i,
        output cmd_ready_o, wdata_ready_o, rdata_v_o, rdata_o,
        output done_v_o, done_err_o, link_o
    );
endinterface

// File: rtl/bsg_iic_cmd_to_link.sv
// Turns one IIC transaction descriptor (+ write bytes) into a bridge request packet and
// consumes the bridge response: read bytes out, or write ACK token check.
module bsg_iic_cmd_to_link #(
    parameter int unsigned iic_data_bits_p = 8,
    parameter int unsigned cord_width_p    = 4,
    parameter int unsigned len_width_p     = 4
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic [cord_width_p-1:0] dest_cord_i,
    output logic                    busy_o,
    bsg_iic_cmd_to_link_if.slave    io
);
    localparam int unsigned data_w_lp   = iic_data_bits_p;
    localparam int unsigned max_len_lp  = (1 << len_width_p) - 1;
    localparam int unsigned max_wlen_lp = max_len_lp - 2;
    localparam logic [7:0]  ack_token_lp = 8'h66;

    typedef enum logic [3:0] {
        IDLE, OHDR, IHDR, ADDR, WDATA, RCNT, RSP_HDR, RSP_ACK, RSP_DATA, DONE
    } state_e;

    state_e                  state_q, state_d;
    logic [6:0]              addr_q, addr_d;
    logic                    read_q, read_d;
    logic                    rs_q, rs_d;
    logic                    err_q, err_d;
    logic [len_width_p-1:0]  len_q, len_d;
    logic [len_width_p-1:0]  cnt_q, cnt_d;
    logic [cord_width_p-1:0] cord_q, cord_d;

    logic                    rx_v, tx_ready;
    logic [data_w_lp-1:0]    rx_data;
    logic                    tx_v, rx_ready;
    logic [data_w_lp-1:0]    tx_data;

    logic                    cmd_ready, wdata_ready, rdata_v, done_v, done_err, busy;
    logic [7:0]              rdata;

    logic                    cmd_legal;
    logic [len_width_p-1:0]  outer_len, inner_len, rsp_len, exp_rsp_len;

    assign rx_v     = io.link_i[data_w_lp+1];
    assign rx_data  = io.link_i[data_w_lp:1];
    assign tx_ready = io.link_i[0];

    // Longest write still leaves room for inner header and address in the outer length field
    assign cmd_legal = (io.cmd_len_i != '0) &&
                       (io.cmd_read_i || (io.cmd_len_i <= len_width_p'(max_wlen_lp)));

    assign inner_len   = read_q ? len_width_p'(2) : len_q + len_width_p'(1);
    assign outer_len   = read_q ? len_width_p'(3) : len_q + len_width_p'(2);
    assign rsp_len     = rx_data[cord_width_p +: len_width_p];
    assign exp_rsp_len = read_q ? len_q : len_width_p'(1);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            addr_q <= '0;
            read_q <= 1'b0;
            rs_q   <= 1'b0;
            err_q  <= 1'b0;
            len_q  <= '0;
            cnt_q  <= '0;
            cord_q <= '0;
        end else begin
            addr_q <= addr_d;
            read_q <= read_d;
            rs_q   <= rs_d;
            err_q  <= err_d;
            len_q  <= len_d;
            cnt_q  <= cnt_d;
            cord_q <= cord_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        read_d      = read_q;
        rs_d        = rs_q;
        err_d       = err_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        cord_d      = cord_q;
        cmd_ready   = 1'b0;
        wdata_ready = 1'b0;
        rdata_v     = 1'b0;
        rdata       = '0;
        done_v      = 1'b0;
        done_err    = 1'b0;
        tx_v        = 1'b0;
        tx_data     = '0;
        rx_ready    = 1'b0;
        busy        = (state_q != IDLE);

        unique case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (io.cmd_v_i) begin
                    addr_d  = io.cmd_addr_i;
                    read_d  = io.cmd_read_i;
                    rs_d    = io.cmd_rs_i;
                    len_d   = io.cmd_len_i;
                    cnt_d   = io.cmd_len_i;
                    cord_d  = dest_cord_i;
                    err_d   = !cmd_legal;
                    state_d = cmd_legal ? OHDR : DONE;
                end
            end
            OHDR: begin
                tx_v = 1'b1;
                tx_data[cord_width_p +: len_width_p] = outer_len;
                tx_data[cord_width_p-1:0]            = cord_q;
                if (tx_ready) state_d = IHDR;
            end
            IHDR: begin
                tx_v = 1'b1;
                tx_data[cord_width_p +: len_width_p] = inner_len;
                tx_data[0]                           = rs_q;
                if (tx_ready) state_d = ADDR;
            end
            ADDR: begin
                tx_v    = 1'b1;
                tx_data = data_w_lp'({addr_q, read_q});
                if (tx_ready) state_d = read_q ? RCNT : WDATA;
            end
            WDATA: begin
                tx_v        = io.wdata_v_i;
                tx_data     = data_w_lp'(io.wdata_i);
                wdata_ready = tx_ready;
                if (io.wdata_v_i && tx_ready) begin
                    cnt_d = cnt_q - len_width_p'(1);
                    if (cnt_q == len_width_p'(1)) state_d = RSP_HDR;
                end
            end
            RCNT: begin
                tx_v    = 1'b1;
                tx_data = data_w_lp'(len_q);
                if (tx_ready) state_d = RSP_HDR;
            end
            RSP_HDR: begin
                rx_ready = 1'b1;
                if (rx_v) begin
                    cnt_d = rsp_len;
                    if (rsp_len != exp_rsp_len) err_d = 1'b1;
                    if (rsp_len == '0)  state_d = DONE;
                    else if (read_q)    state_d = RSP_DATA;
                    else                state_d = RSP_ACK;
                end
            end
            RSP_ACK: begin
                rx_ready = 1'b1;
                if (rx_v) begin
                    if (rx_data[7:0] != ack_token_lp) err_d = 1'b1;
                    state_d = DONE;
                end
            end
            // Drains whatever length the bridge announced, even if it disagrees with the request
            RSP_DATA: begin
                rdata_v  = rx_v;
                rdata    = rx_data[7:0];
                rx_ready = io.rdata_ready_i;
                if (rx_v && io.rdata_ready_i) begin
                    cnt_d = cnt_q - len_width_p'(1);
                    if (cnt_q == len_width_p'(1)) state_d = DONE;
                end
            end
            DONE: begin
                done_v   = 1'b1;
                done_err = err_q;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign io.cmd_ready_o   = cmd_ready;
    assign io.wdata_ready_o = wdata_ready;
    assign io.rdata_v_o     = rdata_v;
    assign io.rdata_o       = rdata;
    assign io.done_v_o      = done_v;
    assign io.done_err_o    = done_err;
    assign io.link_o        = {tx_v, tx_data, rx_ready};
    assign busy_o           = busy;

endmodule

// File: tb/tb_bsg_iic_cmd_to_link.sv
// Table-driven bench for bsg_iic_cmd_to_link: a bridge/host model feeds each vector and
// scoreboard queues hold the request flits and read bytes the DUT must produce.
module tb_bsg_iic_cmd_to_link;
    localparam int unsigned D = 8;
    localparam int unsigned C = 4;
    localparam int unsigned L = 4;
    localparam int unsigned MAXW = (1 << L) - 3;

    typedef struct {
        bit       rd;
        bit [6:0] addr;
        bit [3:0] len;
        bit       rs;
        bit [3:0] cord;
        bit [7:0] base;
        bit [3:0] rsp_len;
        bit [7:0] ack;
        bit       bp;
        bit       early;
        int       abort_at;
        bit       exp_err;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [C-1:0] dest_cord = '0;
    logic         busy;
    logic         lk_v = 1'b0, lk_rdy = 1'b0;
    logic [7:0]   lk_d = '0;

    int errors = 0;
    int checks = 0;
    bit prev_done = 1'b0;

    logic [7:0] tx_q[$];
    logic [7:0] rd_q[$];
    logic [7:0] rsp_q[$];
    vec_t       vecs[16];

    always #5 clk = ~clk;

    bsg_iic_cmd_to_link_if #(.iic_data_bits_p(D), .cord_width_p(C), .len_width_p(L)) bus ();

    bsg_iic_cmd_to_link #(.iic_data_bits_p(D), .cord_width_p(C), .len_width_p(L)) dut (
        .clk_i       (clk),
        .reset_n_i   (rst_n),
        .dest_cord_i (dest_cord),
        .busy_o      (busy),
        .io          (bus.slave)
    );

    assign bus.link_i = {lk_v, lk_d, lk_rdy};

    wire         tx_v   = bus.link_o[D+1];
    wire [D-1:0] tx_d   = bus.link_o[D:1];
    wire         rx_rdy = bus.link_o[0];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input bit rd, input bit [6:0] addr, input bit [3:0] len,
                                input bit rs, input bit [3:0] cord, input bit [7:0] base,
                                input bit [3:0] rsp_len, input bit [7:0] ack, input bit bp,
                                input bit early, input int abort_at, input bit exp_err);
        vec_t v;
        v.rd = rd; v.addr = addr; v.len = len; v.rs = rs; v.cord = cord; v.base = base;
        v.rsp_len = rsp_len; v.ack = ack; v.bp = bp; v.early = early;
        v.abort_at = abort_at; v.exp_err = exp_err;
        return v;
    endfunction

    function automatic logic [7:0] wbyte(input vec_t v, input int i);
        return v.base + 8'(i * 17);
    endfunction

    function automatic logic [7:0] rbyte(input vec_t v, input int i);
        return v.base + 8'(i * 8'h69);
    endfunction

    function automatic bit is_legal(input vec_t v);
        return (v.len != 0) && (v.rd || (32'(v.len) <= MAXW));
    endfunction

    // Reference request packet and response stream for one vector
    task automatic build(input vec_t v);
        int n;
        tx_q.delete(); rd_q.delete(); rsp_q.delete();
        if (!is_legal(v)) return;
        n = v.rd ? 2 : int'(v.len) + 1;
        tx_q.push_back({4'(n + 1), v.cord});
        tx_q.push_back({4'(n), 3'b000, v.rs});
        tx_q.push_back({v.addr, v.rd});
        if (v.rd) tx_q.push_back({4'h0, v.len});
        else for (int i = 0; i < int'(v.len); i++) tx_q.push_back(wbyte(v, i));
        rsp_q.push_back({v.rsp_len, 4'h3});
        if (v.rsp_len != 0) begin
            if (v.rd) begin
                for (int i = 0; i < int'(v.rsp_len); i++) begin
                    rsp_q.push_back(rbyte(v, i));
                    rd_q.push_back(rbyte(v, i));
                end
            end else begin
                rsp_q.push_back(v.ack);
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_link_o"}, 32'(bus.link_o), 0);
        check({tag, "_cmd_ready"}, 32'(bus.cmd_ready_o), 1);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_wdata_ready"}, 32'(bus.wdata_ready_o), 0);
        check({tag, "_rdata_v"}, 32'(bus.rdata_v_o), 0);
        check({tag, "_done_v"}, 32'(bus.done_v_o), 0);
    endtask

    task automatic run_txn(input vec_t v);
        int cyc = 0, acc_cyc = 0, first_f = -1, last_f = -1, nfired = 0, nfl;
        int ridx = 0, widx = 0;
        bit acc = 0, done = 0, whold = 0, rhold = 0, prev_pend = 0, b2b, legal, can_rsp;
        logic [7:0] prev_d = '0;
        logic [7:0] exp;
        build(v);
        nfl = tx_q.size();
        legal = is_legal(v);
        b2b = prev_done;
        prev_done = 0;
        dest_cord = v.cord;
        bus.cmd_addr_i = v.addr; bus.cmd_read_i = v.rd; bus.cmd_len_i = v.len; bus.cmd_rs_i = v.rs;
        while (!done && cyc < 400) begin
            @(negedge clk);
            bus.cmd_v_i = !acc;
            if (!whold) begin
                bus.wdata_v_i = legal && !v.rd && (widx < int'(v.len)) &&
                                (v.bp ? ($urandom_range(0, 2) != 0) : 1'b1);
                bus.wdata_i = wbyte(v, widx);
            end
            lk_rdy = v.bp ? ($urandom_range(0, 2) != 0) : 1'b1;
            can_rsp = acc && (tx_q.size() == 0 || v.early) && (v.abort_at == 0);
            if (!rhold) begin
                lk_v = can_rsp && (ridx < rsp_q.size()) && (v.bp ? ($urandom_range(0, 2) != 0) : 1'b1);
                lk_d = lk_v ? rsp_q[ridx] : 8'h00;
            end
            bus.rdata_ready_i = v.bp ? ($urandom_range(0, 2) != 0) : 1'b1;
            #1;
            cyc++;
            if (cyc == 1 && b2b) begin
                check("done_pulse_one_cycle", 32'(bus.done_v_o), 0);
                check("idle_cmd_ready", 32'(bus.cmd_ready_o), 1);
                check("idle_busy", 32'(busy), 0);
            end
            if (!legal) check("illegal_no_tx", 32'(tx_v), 0);
            if (acc && tx_q.size() != 0) check("rsp_backpressure", 32'(rx_rdy), 0);
            if (prev_pend) begin
                check("tx_hold_v", 32'(tx_v), 1);
                check("tx_hold_d", 32'(tx_d), 32'(prev_d));
            end
            prev_pend = tx_v && !lk_rdy;
            prev_d = tx_d;
            if (tx_v && lk_rdy) begin
                if (tx_q.size() == 0) check("tx_extra_v", 32'(tx_v), 0);
                else begin
                    exp = tx_q.pop_front();
                    check("tx_flit", 32'(tx_d), 32'(exp));
                    nfired++;
                    if (first_f < 0) first_f = cyc;
                    last_f = cyc;
                end
            end
            if (bus.wdata_v_i && bus.wdata_ready_o) begin widx++; whold = 0; end
            else whold = bus.wdata_v_i;
            if (lk_v && rx_rdy) begin ridx++; rhold = 0; end
            else rhold = lk_v;
            if (bus.rdata_v_o && bus.rdata_ready_i) begin
                if (rd_q.size() == 0) check("rdata_extra_v", 32'(bus.rdata_v_o), 0);
                else begin
                    exp = rd_q.pop_front();
                    check("rdata", 32'(bus.rdata_o), 32'(exp));
                end
            end
            if (!acc && bus.cmd_v_i && bus.cmd_ready_o) begin
                acc = 1;
                acc_cyc = cyc;
                if (b2b) check("b2b_accept_cycle", cyc, 1);
            end
            // Mid-WDATA reset: outputs must collapse before the next clock edge
            if (v.abort_at != 0 && nfired == v.abort_at) begin
                #2 rst_n = 1'b0;
                #1 check_reset_outputs("async_rst");
                bus.cmd_v_i = 0; bus.wdata_v_i = 0; lk_v = 0; bus.rdata_ready_i = 0;
                repeat (2) begin
                    @(negedge clk); #1;
                    check("rst_no_done", 32'(bus.done_v_o), 0);
                end
                @(negedge clk) rst_n = 1'b1;
                #1 check_reset_outputs("post_rst");
                prev_done = 0;
                return;
            end
            if (bus.done_v_o) begin
                done = 1;
                check("done_after_accept", 32'(acc), 1);
                check("done_err", 32'(bus.done_err_o), 32'(v.exp_err));
                check("done_busy", 32'(busy), 1);
                check("tx_drained", tx_q.size(), 0);
                check("rdata_drained", rd_q.size(), 0);
                check("rsp_consumed", ridx, rsp_q.size());
                if (legal && !v.bp) check("req_burst_span", last_f - first_f, nfl - 1);
                if (!legal) check("illegal_done_latency_ok", 32'((cyc - acc_cyc) <= 2), 1);
            end
        end
        if (!done) check("timeout_done_v", 32'(bus.done_v_o), 1);
        prev_done = done;
    endtask

    initial begin
        bus.cmd_v_i = 0; bus.cmd_addr_i = '0; bus.cmd_read_i = 0; bus.cmd_len_i = '0;
        bus.cmd_rs_i = 0; bus.wdata_v_i = 0; bus.wdata_i = '0; bus.rdata_ready_i = 0;

        //       rd addr    len rs cord base   rlen ack    bp el abort err
        vecs[0]  = mk(0, 7'h50, 3,  0, 3,  8'hAA, 1,  8'h66, 0, 0, 0, 0);
        vecs[1]  = mk(1, 7'h50, 2,  1, 3,  8'h5A, 2,  8'h00, 0, 0, 0, 0);
        vecs[2]  = mk(0, 7'h2C, 1,  0, 5,  8'h11, 1,  8'h65, 0, 0, 0, 1);
        vecs[3]  = mk(0, 7'h50, 0,  0, 3,  8'h00, 0,  8'h00, 0, 0, 0, 1);
        vecs[4]  = mk(0, 7'h50, 14, 0, 3,  8'h00, 0,  8'h00, 0, 0, 0, 1);
        vecs[5]  = mk(0, 7'h7F, 13, 1, 9,  8'h01, 1,  8'h66, 1, 0, 0, 0);
        vecs[6]  = mk(1, 7'h11, 15, 0, 2,  8'h07, 15, 8'h00, 1, 0, 0, 0);
        vecs[7]  = mk(1, 7'h22, 2,  0, 1,  8'h30, 3,  8'h00, 1, 0, 0, 1);
        vecs[8]  = mk(0, 7'h33, 2,  0, 4,  8'h40, 1,  8'h66, 1, 1, 0, 0);
        vecs[9]  = mk(0, 7'h44, 4,  0, 3,  8'h50, 1,  8'h66, 0, 0, 4, 0);
        vecs[10] = mk(0, 7'h45, 2,  0, 3,  8'h60, 1,  8'h66, 0, 0, 0, 0);
        vecs[11] = mk(1, 7'h00, 1,  0, 15, 8'hF0, 1,  8'h00, 0, 0, 0, 0);
        vecs[12] = mk(0, 7'h12, 5,  0, 6,  8'h70, 2,  8'h66, 1, 0, 0, 1);
        vecs[13] = mk(0, 7'h13, 1,  1, 7,  8'h80, 0,  8'h66, 0, 0, 0, 1);
        vecs[14] = mk(1, 7'h14, 3,  0, 8,  8'h90, 0,  8'h00, 0, 0, 0, 1);
        vecs[15] = mk(1, 7'h15, 0,  0, 3,  8'h00, 0,  8'h00, 0, 0, 0, 1);

        @(negedge clk); #1;
        check_reset_outputs("init_rst");
        @(negedge clk) rst_n = 1'b1;
        #1 check_reset_outputs("idle");

        // First request flit of the basic write, straight from the packet format
        build(vecs[0]);
        check("write_outer_hdr_ref", 32'(tx_q[0]), 32'h53);

        for (int i = 0; i < 16; i++) run_txn(vecs[i]);
        for (int i = 5; i < 9; i++) run_txn(vecs[i]);

        @(negedge clk); #1;
        check("final_done_low", 32'(bus.done_v_o), 0);
        check("final_cmd_ready", 32'(bus.cmd_ready_o), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
